countdown_timer_ctrl: RTL and testbench
=======================================

# countdown_timer_ctrl

Sequencing controller for the two-digit seven-segment time display. Generates the BCD digit pair `timeLeftTen`/`timeLeftOne` that feeds the display decoder directly, counting down once per second from a parameterised start value. Start, pause/resume and reload come from user buttons. On expiry it raises a time-up flag and blinks the display by driving the blank code (4'hF, decoded as all segments off).

## Interface
- `CLK_HZ`, 50_000_000: clock cycles per 1 s tick; must be ≥ 2.
- `BLINK_DIV`, 12_500_000: cycles per blink half-period in EXPIRED; must be ≥ 1.
- `START_TEN`, 3: reload tens digit, 0..9.
- `START_ONE`, 0: reload ones digit, 0..9.
- `clk` input 1: single clock; every register is in this domain.
- `rst` input 1: asynchronous, active-high reset.
- `startBtn` input 1: level, already synchronous to `clk`; rising edge = start/resume.
- `pauseBtn` input 1: level, synchronous; rising edge = pause/resume toggle.
- `reloadBtn` input 1: level, synchronous; rising edge = abort and reload.
- `timeLeftTen` output 4: BCD tens digit, or 4'hF when blanked.
- `timeLeftOne` output 4: BCD ones digit, or 4'hF when blanked.
- `running` output 1: high in RUN.
- `timeUp` output 1: high in EXPIRED.
- `timeUpPulse` output 1: one-cycle pulse on entry to EXPIRED.

## Operation
- Edge detect: each button has a registered previous value. Event = `btn & ~prev`.
  - Reset clears `prev` to 0, so a button held through reset produces one event on the first post-reset cycle.
- States:
  - IDLE: digits = START, prescaler at 0.
  - RUN: prescaler counts 0..CLK_HZ-1; `tick` is asserted when count = CLK_HZ-1, and the count wraps to 0.
  - PAUSE: prescaler and digits hold.
  - EXPIRED: digits = 0,0, blink active.
- Transitions, evaluated per cycle in priority order:
  1. reload event (any state) -> IDLE; digits = START, prescaler = 0, blink phase = 0.
  2. IDLE + start event -> RUN with prescaler = 0. If START is 0,0, go directly to EXPIRED instead.
  3. RUN + tick -> decrement; if the result is 0,0 -> EXPIRED. Expiry wins over a same-cycle pause event.
  4. RUN + pause event without expiry -> PAUSE. A tick in the same cycle is still applied first.
  5. PAUSE + (pause or start event) -> RUN; the prescaler resumes from its held value.
- All other events are ignored. This includes start or pause in EXPIRED, and start in RUN.
- Decrement: if ones ≠ 0, ones-1; else ones = 9 and tens-1. Digits never leave 0..9 except for the blank code.
- Blink: a counter of width `$clog2(BLINK_DIV)` runs only in EXPIRED and toggles the phase every BLINK_DIV cycles. Phase 0 shows 0,0; phase 1 drives both digits to 4'hF.

## Timing
- Reset values: state IDLE, `timeLeftTen` = START_TEN, `timeLeftOne` = START_ONE, `running` 0, `timeUp` 0, `timeUpPulse` 0, prescaler 0, blink counter and phase 0.
- All outputs are registered.
- Button event at edge N -> state change and `running` visible after edge N+1.
  - This counts the one cycle of edge detection; the registered `prev` is compared at edge N+1.
- Tick period: after entering RUN with prescaler 0, the first decrement is visible CLK_HZ cycles later, then every CLK_HZ cycles.
- Expiry: the digits show 0,0, `timeUp` rises and `timeUpPulse` pulses, all in the same cycle. `timeUpPulse` is high for exactly one cycle.
- Blink: the first phase-1 (blank) output appears BLINK_DIV cycles after EXPIRED entry.
- Reset asserted mid-run returns all outputs to reset values immediately (asynchronous). No event is generated on release unless a button is held high.

## Structure
- Package `timer_pkg`:
  - state enum {IDLE, RUN, PAUSE, EXPIRED}
  - `DIGIT_BLANK = 4'hF`
  - `DIGIT_MAX = 4'd9`
- Sub-module `tick_gen` (parameter DIV; ports `clk`, `rst`, `en`, `clr`, `tick`): the prescaler.
  - `en` is high in RUN only.
  - `clr` is high on IDLE->RUN and on reload.
- Edge detect, FSM, BCD decrement and blink logic all live in `countdown_timer_ctrl`.
- Elaboration-time check: START digits ≤ 9.

## Test plan
Parameters: CLK_HZ=4, BLINK_DIV=2, START 1,2.
1. Reset, then release -> outputs 1,2; `running`=0; `timeUp`=0; all held for 20 cycles with no button activity.
2. Start pulse -> `running` 1 after one edge. Digits step 1,2 -> 1,1 -> 1,0 -> 0,9 (borrow), one step every 4 cycles. Reaching 0,0 happens 48 cycles after RUN entry, and `timeUpPulse` is exactly 1 cycle.
3. Pause event 2 cycles into a prescaler period -> digits frozen for 30 cycles. Resume -> the next decrement arrives exactly 2 cycles after RUN re-entry.
4. Reload event in the same cycle as a tick in RUN -> IDLE with digits 1,2; no decrement applied; a subsequent start gives the first decrement 4 cycles after RUN entry.
5. In EXPIRED -> digits alternate 0,0 / F,F every 2 cycles. Start and pause are ignored. Reload returns to IDLE showing 1,2 with `timeUp`=0.
6. START 0,0 variant: start event -> EXPIRED directly, with `timeUpPulse` once and `running` never high.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown display controller.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_MAX   = 4'd9;

  // BCD decrement of a two-digit value; callers never pass 0,0.
  function automatic logic [7:0] bcd_dec(input logic [3:0] ten, input logic [3:0] one);
    if (one != 4'd0) begin
      return {ten, one - 4'd1};
    end
    return {ten - 4'd1, DIGIT_MAX};
  endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the terminal count.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_top;

  assign at_top = (cnt_q == CW'(DIV - 1));
  assign tick   = en & at_top;

  // Clear wins over enable so a reload coinciding with a tick restarts the period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_top ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Two-digit BCD countdown sequencer with start/pause/reload buttons and blinking expiry.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BLINK_DIV = 12_500_000,
  parameter int unsigned START_TEN = 3,
  parameter int unsigned START_ONE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startBtn,
  input  logic       pauseBtn,
  input  logic       reloadBtn,
  output logic [3:0] timeLeftTen,
  output logic [3:0] timeLeftOne,
  output logic       running,
  output logic       timeUp,
  output logic       timeUpPulse
);

  if (START_TEN > 9 || START_ONE > 9) begin : g_bad_start
    $error("countdown_timer_ctrl: START digits must be 0..9");
  end
  if (CLK_HZ < 2 || BLINK_DIV < 1) begin : g_bad_div
    $error("countdown_timer_ctrl: CLK_HZ must be >= 2 and BLINK_DIV >= 1");
  end

  localparam int unsigned BW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [3:0]  ST_TEN  = 4'(START_TEN);
  localparam logic [3:0]  ST_ONE  = 4'(START_ONE);
  localparam logic        ST_ZERO = (START_TEN == 0) && (START_ONE == 0);

  // Bit order: {reload, pause, start}; events are registered, adding one cycle of latency.
  logic [2:0] btn_prev_q, btn_evt_q, btns;
  logic       start_evt, pause_evt, reload_evt;

  assign btns       = {reloadBtn, pauseBtn, startBtn};
  assign start_evt  = btn_evt_q[0];
  assign pause_evt  = btn_evt_q[1];
  assign reload_evt = btn_evt_q[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev_q <= '0;
      btn_evt_q  <= '0;
    end else begin
      btn_prev_q <= btns;
      btn_evt_q  <= btns & ~btn_prev_q;
    end
  end

  state_t          state_q, state_d;
  logic [3:0]      tens_q, tens_d, ones_q, ones_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic [3:0]      ten_out_q, ten_out_d, one_out_q, one_out_d;
  logic            running_q, time_up_q, pulse_q;
  logic            tick, pre_clr;
  logic [7:0]      dec;

  tick_gen #(
    .DIV (CLK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == RUN),
    .clr  (pre_clr),
    .tick (tick)
  );

  assign dec = bcd_dec(tens_q, ones_q);

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    pre_clr = 1'b0;
    if (reload_evt) begin
      state_d = IDLE;
      tens_d  = ST_TEN;
      ones_d  = ST_ONE;
      pre_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_evt) begin
            pre_clr = 1'b1;
            state_d = ST_ZERO ? EXPIRED : RUN;
          end
        end
        RUN: begin
          // A tick is applied before a same-cycle pause; expiry overrides the pause.
          if (tick) begin
            tens_d = dec[7:4];
            ones_d = dec[3:0];
            if (dec == 8'h00) begin
              state_d = EXPIRED;
            end else if (pause_evt) begin
              state_d = PAUSE;
            end
          end else if (pause_evt) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (pause_evt || start_evt) begin
            state_d = RUN;
          end
        end
        EXPIRED: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (state_d == EXPIRED && state_q == EXPIRED) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        phase_d = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
      end
    end
    ten_out_d = (state_d == EXPIRED && phase_d) ? DIGIT_BLANK : tens_d;
    one_out_d = (state_d == EXPIRED && phase_d) ? DIGIT_BLANK : ones_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tens_q      <= ST_TEN;
      ones_q      <= ST_ONE;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      ten_out_q   <= ST_TEN;
      one_out_q   <= ST_ONE;
      running_q   <= 1'b0;
      time_up_q   <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      ten_out_q   <= ten_out_d;
      one_out_q   <= one_out_d;
      running_q   <= (state_d == RUN);
      time_up_q   <= (state_d == EXPIRED);
      pulse_q     <= (state_d == EXPIRED) && (state_q != EXPIRED);
    end
  end

  assign timeLeftTen = ten_out_q;
  assign timeLeftOne = one_out_q;
  assign running     = running_q;
  assign timeUp      = time_up_q;
  assign timeUpPulse = pulse_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench: START 1,2 instance for the main sequence, START 0,0 instance for direct expiry.
module tb_countdown_timer_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start_btn, pause_btn, reload_btn, start0_btn;

  logic [3:0] ten, one, ten0, one0;
  logic       running, time_up, pulse, running0, time_up0, pulse0;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse0_cnt = 0;
  bit run0_seen = 1'b0;

  always #5 clk = ~clk;

  countdown_timer_ctrl #(
    .CLK_HZ    (4),
    .BLINK_DIV (2),
    .START_TEN (1),
    .START_ONE (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .startBtn    (start_btn),
    .pauseBtn    (pause_btn),
    .reloadBtn   (reload_btn),
    .timeLeftTen (ten),
    .timeLeftOne (one),
    .running     (running),
    .timeUp      (time_up),
    .timeUpPulse (pulse)
  );

  countdown_timer_ctrl #(
    .CLK_HZ    (4),
    .BLINK_DIV (2),
    .START_TEN (0),
    .START_ONE (0)
  ) dut0 (
    .clk         (clk),
    .rst         (rst),
    .startBtn    (start0_btn),
    .pauseBtn    (pause_btn),
    .reloadBtn   (reload_btn),
    .timeLeftTen (ten0),
    .timeLeftOne (one0),
    .running     (running0),
    .timeUp      (time_up0),
    .timeUpPulse (pulse0)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (running0) run0_seen = 1'b1;
      if (pulse0) pulse0_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 0 start, 1 pause, 2 reload, 3 start of the 0,0 instance; high for exactly one posedge.
  task automatic pulse_btn(input int idx);
    case (idx)
      0: start_btn = 1'b1;
      1: pause_btn = 1'b1;
      2: reload_btn = 1'b1;
      default: start0_btn = 1'b1;
    endcase
    @(negedge clk);
    start_btn  = 1'b0;
    pause_btn  = 1'b0;
    reload_btn = 1'b0;
    start0_btn = 1'b0;
  endtask

  logic [7:0] exp_seq [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                               8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] cur;
    rst = 1'b1;
    start_btn = 1'b0; pause_btn = 1'b0; reload_btn = 1'b0; start0_btn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_digits", {ten, one}, 8'h12);
    check("rst_flags", {running, time_up, pulse}, 3'b000);
    rst = 1'b0;

    // Idle hold
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_digits", {ten, one}, 8'h12);
    end
    check("idle_flags", {running, time_up, pulse}, 3'b000);
    check("idle0_digits", {ten0, one0}, 8'h00);
    check("idle0_timeup", time_up0, 1'b0);

    // Countdown to expiry, 4 cycles per step
    pulse_btn(0);
    @(negedge clk);
    check("run_entry", running, 1'b1);
    check("run_entry_digits", {ten, one}, 8'h12);
    cur = 8'h12;
    for (int k = 0; k < 12; k++) begin
      repeat (3) @(negedge clk);
      check("dec_hold", {ten, one}, cur);
      @(negedge clk);
      check("dec_step", {ten, one}, exp_seq[k]);
      if (k < 11) check("no_early_pulse", pulse, 1'b0);
      cur = exp_seq[k];
    end
    check("expire_flags", {running, time_up, pulse}, 3'b011);

    // Blink: blank from 2 cycles after entry, every 2 cycles
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) check("pulse_one_cycle", pulse, 1'b0);
      check("blink", {ten, one}, (((i / 2) % 2) != 0) ? 8'hFF : 8'h00);
    end
    pulse_btn(0);
    pulse_btn(1);
    @(negedge clk);
    check("expired_ignore", {running, time_up}, 2'b01);
    check("expired_blink_on", {ten, one}, 8'hFF);
    pulse_btn(2);
    @(negedge clk);
    check("reload_digits", {ten, one}, 8'h12);
    check("reload_flags", {running, time_up}, 2'b00);

    // Pause two cycles into a prescaler period, resume keeps the partial count
    pulse_btn(0);
    @(negedge clk);
    check("run2_entry", running, 1'b1);
    repeat (3) @(negedge clk);
    check("run2_hold", {ten, one}, 8'h12);
    @(negedge clk);
    check("run2_tick", {ten, one}, 8'h11);
    pulse_btn(1);
    @(negedge clk);
    check("pause_entry", running, 1'b0);
    repeat (30) @(negedge clk);
    check("pause_frozen", {ten, one}, 8'h11);
    check("pause_running", running, 1'b0);
    pulse_btn(1);
    @(negedge clk);
    check("resume_running", running, 1'b1);
    @(negedge clk);
    check("resume_hold", {ten, one}, 8'h11);
    @(negedge clk);
    check("resume_tick", {ten, one}, 8'h10);

    // Reload coinciding with a tick
    repeat (2) @(negedge clk);
    pulse_btn(2);
    @(negedge clk);
    check("reload_tick_digits", {ten, one}, 8'h12);
    check("reload_tick_running", running, 1'b0);
    @(negedge clk);
    check("reload_tick_stable", {ten, one}, 8'h12);
    pulse_btn(0);
    @(negedge clk);
    check("run3_entry", running, 1'b1);
    repeat (3) @(negedge clk);
    check("run3_hold", {ten, one}, 8'h12);
    @(negedge clk);
    check("run3_tick", {ten, one}, 8'h11);

    // START 0,0 goes straight to expiry
    pulse_btn(3);
    @(negedge clk);
    check("zero_expire", {running0, time_up0, pulse0}, 3'b011);
    check("zero_digits", {ten0, one0}, 8'h00);
    @(negedge clk);
    check("zero_pulse_end", pulse0, 1'b0);
    @(negedge clk);
    check("zero_blink", {ten0, one0}, 8'hFF);
    check("zero_pulse_count", pulse0_cnt, 1);
    check("zero_never_running", run0_seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
